// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer
//
// Multi-cycle shift-and-add multiplier that borrows the core's shared
// combinational ALU. The product is W bits wide (modulo 2^W).
//
// While idle, the core's direct ALU request (ext_*) passes straight through to
// the ALU. While busy, the sequencer owns the ALU and issues ADD, LSH and RSH
// operations to step the multiply one bit of the multiplier at a time.
//
// The ALU's LSH and RSH opcodes are expected to shift operand A by one bit
// position. The sequencer drives operand B to zero for those operations.
//
// Ports
//   clk_i            clock; all state updates happen on the rising edge
//   reset_i          asynchronous, active-high reset
//   start_i          multiply request; accepted only while busy_o is low
//   mul_a_i, mul_b_i multiplicand and multiplier, sampled on an accepted start
//   busy_o           high from the cycle after accept until the result is taken
//   result_o         product; meaningful only while result_valid_o is high
//   result_valid_o   result available; result_o is held stable while high
//   result_ready_i   consumer takes the result when high with result_valid_o
//   ext_a_i/b_i/op_i core's direct ALU request, passed through while idle
//   ext_gnt_o        high when ext_* owns the ALU (the inverse of busy_o)
//   alu_a_o/b_o/op_o ALU operand and opcode mux outputs
//   alu_out_i        combinational ALU result
module alu_mul_sequencer #(
  parameter int             W      = 8,
  parameter int             Ops    = 4,
  parameter logic [Ops-1:0] OP_ADD = Ops'(0),
  parameter logic [Ops-1:0] OP_LSH = Ops'(4),
  parameter logic [Ops-1:0] OP_RSH = Ops'(5)
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           start_i,
  input  logic [W-1:0]   mul_a_i,
  input  logic [W-1:0]   mul_b_i,
  output logic           busy_o,
  output logic [W-1:0]   result_o,
  output logic           result_valid_o,
  input  logic           result_ready_i,
  input  logic [W-1:0]   ext_a_i,
  input  logic [W-1:0]   ext_b_i,
  input  logic [Ops-1:0] ext_op_i,
  output logic           ext_gnt_o,
  output logic [W-1:0]   alu_a_o,
  output logic [W-1:0]   alu_b_o,
  output logic [Ops-1:0] alu_op_o,
  input  logic [W-1:0]   alu_out_i
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EVAL = 3'd1,
    S_ADDS = 3'd2,
    S_SHA  = 3'd3,
    S_SHB  = 3'd4,
    S_DONE = 3'd5
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] ra_q, ra_d;
  logic [W-1:0] rb_q, rb_d;

  // State and datapath registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
    end
  end

  // Next-state logic. Each pass of the loop retires one multiplier bit:
  // EVAL tests it, ADDS folds the shifted multiplicand in when the bit is
  // set, and SHA/SHB advance both operands by one bit position. The loop ends
  // as soon as the remaining multiplier is zero, so high zero bits cost nothing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_EVAL;
      S_EVAL: begin
        if (rb_q == '0)   state_d = S_DONE;
        else if (rb_q[0]) state_d = S_ADDS;
        else              state_d = S_SHA;
      end
      S_ADDS: state_d = S_SHA;
      S_SHA:  state_d = S_SHB;
      S_SHB:  state_d = S_EVAL;
      // A start in the same cycle as the handshake is deliberately not
      // looked at; it is seen from IDLE on the following cycle.
      S_DONE: if (result_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath register updates. All arithmetic goes through the shared ALU;
  // the ALU result is captured into whichever register the state is updating.
  always_comb begin
    acc_d = acc_q;
    ra_d  = ra_q;
    rb_d  = rb_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          ra_d  = mul_a_i;
          rb_d  = mul_b_i;
          acc_d = '0;
        end
      end
      S_ADDS: acc_d = alu_out_i;  // carry out of bit W-1 is dropped
      S_SHA:  ra_d  = alu_out_i;
      S_SHB:  rb_d  = alu_out_i;
      default: ;
    endcase
  end

  // ALU operand/opcode mux. EVAL and DONE do not need the ALU, so they park it
  // on a harmless 0 + 0.
  always_comb begin
    alu_a_o  = '0;
    alu_b_o  = '0;
    alu_op_o = OP_ADD;
    case (state_q)
      S_IDLE: begin
        alu_a_o  = ext_a_i;
        alu_b_o  = ext_b_i;
        alu_op_o = ext_op_i;
      end
      S_ADDS: begin
        alu_a_o  = acc_q;
        alu_b_o  = ra_q;
        alu_op_o = OP_ADD;
      end
      S_SHA: begin
        alu_a_o  = ra_q;
        alu_op_o = OP_LSH;
      end
      S_SHB: begin
        alu_a_o  = rb_q;
        alu_op_o = OP_RSH;
      end
      default: ;
    endcase
  end

  assign busy_o         = (state_q != S_IDLE);
  assign ext_gnt_o      = ~busy_o;
  assign result_valid_o = (state_q == S_DONE);
  assign result_o       = acc_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
module tb_alu_mul_sequencer;

  localparam logic [3:0] ADD = 4'h0;
  localparam logic [3:0] LSH = 4'h4;
  localparam logic [3:0] RSH = 4'h5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] mul_a = '0, mul_b = '0;
  logic [7:0] ext_a = '0, ext_b = '0;
  logic [3:0] ext_op = '0;
  logic       busy, rv, gnt;
  logic [7:0] result, alu_a, alu_b, alu_out;
  logic [3:0] alu_op;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b1;

  always #5 clk = ~clk;

  alu_mul_sequencer #(.W(8), .Ops(4)) dut (
    .clk_i          (clk),
    .reset_i        (rst),
    .start_i        (start),
    .mul_a_i        (mul_a),
    .mul_b_i        (mul_b),
    .busy_o         (busy),
    .result_o       (result),
    .result_valid_o (rv),
    .result_ready_i (ready),
    .ext_a_i        (ext_a),
    .ext_b_i        (ext_b),
    .ext_op_i       (ext_op),
    .ext_gnt_o      (gnt),
    .alu_a_o        (alu_a),
    .alu_b_o        (alu_b),
    .alu_op_o       (alu_op),
    .alu_out_i      (alu_out)
  );

  // Stand-in for the shared combinational ALU
  always_comb begin
    case (alu_op)
      ADD:     alu_out = alu_a + alu_b;
      LSH:     alu_out = alu_a << 1;
      RSH:     alu_out = alu_a >> 1;
      default: alu_out = alu_a ^ alu_b;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycles from the start cycle until result_valid is first seen
  function automatic int exp_latency(input logic [7:0] b);
    int k = 0;
    for (int i = 0; i < 8; i++) if (b[i]) k = i + 1;
    return 2 + 3 * k + $countones(b);
  endfunction

  // Behavioural model: idle / counting down / result waiting
  bit         m_busy  = 1'b0;
  bit         m_valid = 1'b0;
  bit         m_acc0  = 1'b1;
  int         m_rem   = 0;
  logic [7:0] m_res   = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_acc0  <= 1'b1;
    end else if (!m_busy) begin
      if (start) begin
        m_busy  <= 1'b1;
        m_valid <= 1'b0;
        m_acc0  <= 1'b0;
        m_rem   <= exp_latency(mul_b) - 1;
        m_res   <= mul_a * mul_b;
      end
    end else if (!m_valid) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) m_valid <= 1'b1;
    end else if (ready) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_busy);
      chk("ext_gnt", gnt, !m_busy);
      chk("result_valid", rv, m_valid);
      if (m_valid) begin
        chk("result", result, m_res);
        chk("alu_a_done", alu_a, 0);
        chk("alu_b_done", alu_b, 0);
        chk("alu_op_done", alu_op, ADD);
      end
      if (m_acc0 && !m_busy) chk("result_after_reset", result, 0);
      if (!m_busy) begin
        chk("alu_a_pass", alu_a, ext_a);
        chk("alu_b_pass", alu_b, ext_b);
        chk("alu_op_pass", alu_op, ext_op);
      end else begin
        chk("alu_op_legal", (alu_op == ADD || alu_op == LSH || alu_op == RSH), 1);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // One multiply with ready held high; checks product, latency, and release
  task automatic run_mul(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_res, input int exp_lat);
    int         cnt;
    bit         seen;
    logic [7:0] got;
    cnt  = 0;
    seen = 1'b0;
    got  = '0;
    ready = 1'b1;
    mul_a = a;
    mul_b = b;
    start = 1'b1;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      cnt++;
      if (rv) begin
        seen = 1'b1;
        got  = result;
      end
      #1;
      start = 1'b0;
    end
    chk("mul_done_seen", seen, 1);
    chk("mul_latency", cnt, exp_lat);
    chk("mul_product", got, exp_res);
    tick();
    chk("busy_after_handshake", busy, 0);
  endtask

  initial begin
    int w;
    #1;
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_busy", busy, 0);
    chk("reset_valid", rv, 0);
    chk("reset_result", result, 0);
    chk("reset_gnt", gnt, 1);
    rst = 1'b0;
    tick();

    // Pass-through while idle
    ext_a = 8'h12; ext_b = 8'h34; ext_op = ADD;
    tick();
    chk("pass_a", alu_a, 8'h12);
    chk("pass_b", alu_b, 8'h34);
    chk("pass_op", alu_op, ADD);
    chk("pass_gnt", gnt, 1);
    ext_op = 4'hF;

    // Reset in the middle of a multiply
    ready = 1'b1; mul_a = 8'd13; mul_b = 8'd11; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("midrun_busy", busy, 1);
    chk("midrun_gnt", gnt, 0);
    chk("midrun_alu_not_ext", (alu_op != ext_op), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", rv, 0);
    chk("midrst_gnt", gnt, 1);
    chk("midrst_result", result, 0);
    #1;
    rst = 1'b0;
    tick();
    run_mul(8'd2, 8'd3, 8'd6, 10);

    // Directed products with hand-computed latencies
    run_mul(8'd13, 8'd11, 8'h8F, 17);
    run_mul(8'd20, 8'd20, 8'h90, 19);
    run_mul(8'd255, 8'd255, 8'h01, 34);
    run_mul(8'd200, 8'd0, 8'h00, 2);
    run_mul(8'd0, 8'h80, 8'h00, 27);

    // Backpressure: result held while ready is low, start ignored
    ready = 1'b0; mul_a = 8'd5; mul_b = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    w = 0;
    while (!rv && w < 60) begin
      tick();
      w++;
    end
    chk("bp_valid_seen", rv, 1);
    for (int i = 0; i < 10; i++) begin
      start = i[0];
      mul_a = 8'd9;
      tick();
      chk("bp_result_held", result, 8'd15);
      chk("bp_busy", busy, 1);
      chk("bp_valid_held", rv, 1);
    end
    // Handshake with start high: ignored this cycle, accepted the next
    ready = 1'b1; start = 1'b1; mul_a = 8'd1; mul_b = 8'd1;
    tick();
    chk("bp_idle_after_hs", busy, 0);
    tick();
    chk("bp_restart_accepted", busy, 1);
    start = 1'b0;
    w = 0;
    while (!rv && w < 60) begin
      tick();
      w++;
    end
    chk("bp_second_valid", rv, 1);
    chk("bp_second_result", result, 8'd1);
    tick();
    chk("bp_second_idle", busy, 0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 3) == 0);
      mul_a = 8'($urandom);
      case ($urandom_range(0, 7))
        0:       mul_b = 8'h00;
        1:       mul_b = 8'hFF;
        2:       mul_b = 8'h80;
        default: mul_b = 8'($urandom);
      endcase
      ready  = ($urandom_range(0, 2) != 0);
      ext_a  = 8'($urandom);
      ext_b  = 8'($urandom);
      ext_op = 4'($urandom);
      rst    = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; start = 1'b0; ready = 1'b1;
    repeat (60) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Multi-cycle controller that sequences the shared combinational ALU to compute W-bit (modulo 2^W) unsigned products by shift-and-add.
- Owns the ALU operand/opcode mux. When idle, it passes the core's direct ALU request through. When busy, it drives the ALU with ADD/LSH/RSH ops from the definitions package.
- Sits between the core's execute stage and the ALU. Uses a start/busy handshake in and a valid/ready handshake out.

Parameters:
- W, 8, datapath width (operands, accumulator, result).
- Ops, 4, ALU opcode width (matches the ALU OP port).

Ports:
- Clk  input  1  clock, all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- start  input  1  request a multiply; accepted only when busy=0.
- mul_a  input  W  multiplicand, sampled on accepted start.
- mul_b  input  W  multiplier, sampled on accepted start.
- busy  output  1  high from the cycle after accept until the result is consumed.
- result  output  W  product modulo 2^W; valid only when result_valid=1.
- result_valid  output  1  result is held stable while high.
- result_ready  input  1  consumer accepts the result when high together with result_valid.
- ext_a  input  W  core's direct ALU operand A (pass-through).
- ext_b  input  W  core's direct ALU operand B (pass-through).
- ext_op  input  Ops  core's direct ALU opcode (pass-through).
- ext_gnt  output  1  high when ext_* drives the ALU (equals !busy).
- alu_a  output  W  to ALU InputA.
- alu_b  output  W  to ALU InputB.
- alu_op  output  Ops  to ALU OP.
- alu_out  input  W  from ALU Out.

Behaviour:
- Registers: state, acc[W], ra[W], rb[W]. Reset clears all to 0 and sets state to IDLE. Reset outputs: busy=0, result_valid=0, result=0, ext_gnt=1.
- Reset is honoured mid-operation. The in-flight multiply is discarded and no result_valid is produced.
- ALU mux: in IDLE, alu_a=ext_a, alu_b=ext_b, alu_op=ext_op. In every other state the values are as listed per state.
- IDLE:
  - If start, latch ra=mul_a, rb=mul_b, acc=0, then go to EVAL. busy rises next cycle.
  - start is ignored whenever busy=1.
- EVAL: alu_a=0, alu_b=0, alu_op=ADD. If rb==0, go to DONE; else if rb[0], go to ADDS; else go to SHA.
- ADDS: alu_a=acc, alu_b=ra, alu_op=ADD. acc<=alu_out (carry discarded). Go to SHA.
- SHA: alu_a=ra, alu_b=0, alu_op=LSH. ra<=alu_out. Go to SHB.
- SHB: alu_a=rb, alu_b=0, alu_op=RSH. rb<=alu_out. Go to EVAL.
- DONE:
  - result=acc, result_valid=1; ALU inputs driven as in EVAL.
  - If result_ready, go to IDLE; busy and result_valid drop the next cycle.
  - A start asserted in the same cycle as the accept is ignored. It is accepted the following cycle if still asserted.
- busy = (state != IDLE). ext_gnt = !busy.
- Latency: with start accepted at edge T, result_valid is first high in cycle T+2+3k+p.
  - k = index of the highest set bit of mul_b plus 1 (k=0 if mul_b=0).
  - p = popcount(mul_b).
  - Maximum is 2+3W+W = 34 cycles for W=8.
- mul_b=0 terminates after EVAL and returns result 0 regardless of mul_a.
- mul_a=0 runs the full iteration count and returns 0.
- The loop always terminates, because rb reaches 0 after at most W RSH steps.
- result_valid with result_ready held low holds result and state indefinitely. busy stays high and ext_gnt stays low.
- The block does not interpret ALU opcodes other than ADD/LSH/RSH. Pass-through is purely combinational.

Test Plan:
- Reset mid-run: start 13*11, assert Reset at cycle 5 -> all outputs at reset values, ext_gnt=1. A new 2*3 afterwards returns 6.
- mul_a=13, mul_b=11, result_ready=1 -> result=0x8F (143), result_valid at T+2+12+3=T+17, busy low the following cycle.
- mul_a=20, mul_b=20 -> result=0x90 (400 mod 256). mul_a=255, mul_b=255 -> result=0x01.
- mul_a=200, mul_b=0 -> result=0 at T+2. mul_a=0, mul_b=0x80 -> result=0 at T+27.
- Backpressure: 5*3 with result_ready low for 10 cycles -> result=15 held, busy=1, start pulses ignored. On ready, one handshake, then IDLE.
- Pass-through: idle, ext_a=0x12, ext_b=0x34, ext_op=ADD -> alu_a/alu_b/alu_op mirror these, ext_gnt=1. During a multiply, alu_* ignore ext_* and ext_gnt=0.
